// File: rtl/m_ext_div_seq_if.sv
// m_ext_div_seq_if: request/response bundle between the control unit and the
// RV32M divide sequencer. The control unit drives the master side.
interface m_ext_div_seq_if #(
   parameter int XLEN = 32
);
   logic            ip_start;
   logic [2:0]      ip_funct_3;
   logic [XLEN-1:0] ip_operand_a;
   logic [XLEN-1:0] ip_operand_b;
   logic            ip_flush;
   logic            op_busy;
   logic            op_done;
   logic [XLEN-1:0] op_result;

   modport master (
      output ip_start, ip_funct_3, ip_operand_a, ip_operand_b, ip_flush,
      input  op_busy, op_done, op_result
   );

   modport slave (
      input  ip_start, ip_funct_3, ip_operand_a, ip_operand_b, ip_flush,
      output op_busy, op_done, op_result
   );
endinterface

// File: rtl/m_ext_div_seq.sv
// m_ext_div_seq: iterative restoring divider for DIV/DIVU/REM/REMU, one
// quotient bit per clock, with pipeline stall and one-cycle result strobe.
// Optional macro DIV_SPECIAL_FAST_EN: divide-by-zero and signed overflow are
// resolved at start and complete with latency 1.
module m_ext_div_seq #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input logic            ip_clk,
   input logic            ip_rst_n,
   m_ext_div_seq_if.slave bus
);

   localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN-1);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t           state_q, state_d;
   logic [XLEN-1:0]  divisor_q, rem_q, quo_q, result_q;
   logic [CNT_W-1:0] cnt_q;
   logic             is_rem_q, q_neg_q, r_neg_q;

   logic             in_signed, ready, accept;
   logic             q_neg_in, r_neg_in;
   logic [XLEN-1:0]  abs_a, abs_b, q_fix, r_fix;
   logic [XLEN:0]    trial;
   logic             unused_funct3_msb;
`ifdef DIV_SPECIAL_FAST_EN
   logic             special;
   logic [XLEN-1:0]  special_res;
`endif

   // Start decode: acceptance, operand magnitudes and sign bits to latch
   always_comb begin
      unused_funct3_msb = bus.ip_funct_3[2];
      in_signed = ~bus.ip_funct_3[0];
      ready     = (state_q == IDLE) || (state_q == DONE);
      accept    = ready && bus.ip_start && !bus.ip_flush;
      abs_a     = (in_signed && bus.ip_operand_a[XLEN-1]) ? -bus.ip_operand_a : bus.ip_operand_a;
      abs_b     = (in_signed && bus.ip_operand_b[XLEN-1]) ? -bus.ip_operand_b : bus.ip_operand_b;
      // Quotient sign is dropped for b=0 so the all-ones quotient survives FIX;
      // the remainder sign is kept because negating |a| restores a exactly.
      q_neg_in  = in_signed && (bus.ip_operand_a[XLEN-1] ^ bus.ip_operand_b[XLEN-1])
                  && (bus.ip_operand_b != '0);
      r_neg_in  = in_signed && bus.ip_operand_a[XLEN-1];
`ifdef DIV_SPECIAL_FAST_EN
      special     = 1'b0;
      special_res = '0;
      if (bus.ip_operand_b == '0) begin
         special     = 1'b1;
         special_res = bus.ip_funct_3[1] ? bus.ip_operand_a : '1;
      end else if (in_signed && (bus.ip_operand_a == MIN_NEG) && (bus.ip_operand_b == '1)) begin
         special     = 1'b1;
         special_res = bus.ip_funct_3[1] ? '0 : MIN_NEG;
      end
`endif
   end

   // Iteration trial subtraction and final sign correction
   always_comb begin
      trial = {rem_q, quo_q[XLEN-1]} - {1'b0, divisor_q};
      q_fix = q_neg_q ? -quo_q : quo_q;
      r_fix = r_neg_q ? -rem_q : rem_q;
   end

   // State register
   always_ff @(posedge ip_clk or negedge ip_rst_n) begin
      if (!ip_rst_n) state_q <= IDLE;
      else           state_q <= state_d;
   end

   // Next-state logic; flush has priority over start and over progress
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
`ifdef DIV_SPECIAL_FAST_EN
               state_d = special ? DONE : CALC;
`else
               state_d = CALC;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            if (bus.ip_flush)            state_d = IDLE;
            else if (cnt_q == LAST_CNT)  state_d = FIX;
         end
         FIX:     state_d = bus.ip_flush ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs: stall covers the accepting cycle, CALC and FIX
   always_comb begin
      bus.op_busy   = accept || (state_q == CALC) || (state_q == FIX);
      bus.op_done   = (state_q == DONE);
      bus.op_result = result_q;
   end

   // Datapath: operand latch, shift-subtract iteration, result capture
   always_ff @(posedge ip_clk or negedge ip_rst_n) begin
      if (!ip_rst_n) begin
         divisor_q <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         result_q  <= '0;
         cnt_q     <= '0;
         is_rem_q  <= 1'b0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
      end else if (accept) begin
         divisor_q <= abs_b;
         quo_q     <= abs_a;
         rem_q     <= '0;
         cnt_q     <= '0;
         is_rem_q  <= bus.ip_funct_3[1];
         q_neg_q   <= q_neg_in;
         r_neg_q   <= r_neg_in;
`ifdef DIV_SPECIAL_FAST_EN
         if (special) result_q <= special_res;
`endif
      end else if ((state_q == CALC) && !bus.ip_flush) begin
         quo_q <= {quo_q[XLEN-2:0], ~trial[XLEN]};
         rem_q <= trial[XLEN] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]} : trial[XLEN-1:0];
         cnt_q <= cnt_q + CNT_W'(1);
      end else if ((state_q == FIX) && !bus.ip_flush) begin
         result_q <= is_rem_q ? r_fix : q_fix;
      end
   end

endmodule

// File: tb/tb_m_ext_div_seq.sv
// tb_m_ext_div_seq: directed vector table, corner sequences (flush,
// back-to-back, mid-operation reset) and random ops against an arithmetic model.
module tb_m_ext_div_seq;

   localparam int XLEN = 32;

   logic ip_clk_tb = 1'b0;
   logic ip_rst_n_tb;

   always #5 ip_clk_tb = ~ip_clk_tb;

   m_ext_div_seq_if #(.XLEN(XLEN)) bus ();

   m_ext_div_seq #(.XLEN(XLEN), .CNT_W(6)) dut (
      .ip_clk   (ip_clk_tb),
      .ip_rst_n (ip_rst_n_tb),
      .bus      (bus)
   );

   typedef struct {
      string       name;
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] last_exp = '0;
   vec_t        vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Architectural result from the RV32M rules, plain arithmetic
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
      if (!f[0]) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : 32'h8000_0000;
         sa = a;
         sb = b;
         return f[1] ? 32'(sa % sb) : 32'(sa / sb);
      end
      return f[1] ? (a % b) : (a / b);
   endfunction

   function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_SPECIAL_FAST_EN
      if (b == 32'd0) return 1;
      if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`endif
      return 34;
   endfunction

   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      bus.ip_funct_3   = f;
      bus.ip_operand_a = a;
      bus.ip_operand_b = b;
      bus.ip_start     = 1'b1;
   endtask

   // Called in the start cycle; lat counts edges from the start edge to done
   task automatic complete(output logic [31:0] res, output int lat, output int busy_n);
      #1;
      busy_n = bus.op_busy ? 1 : 0;
      @(posedge ip_clk_tb);
      #1;
      bus.ip_start = 1'b0;
      lat = 1;
      while (!bus.op_done && lat < 100) begin
         if (bus.op_busy) busy_n++;
         @(posedge ip_clk_tb);
         #1;
         lat++;
      end
      res = bus.op_result;
   endtask

   task automatic run_check(input string name, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
      logic [31:0] res;
      int          lat, busy_n, el;
      el = exp_lat(f, a, b);
      issue(f, a, b);
      complete(res, lat, busy_n);
      chk({name, "_result"}, res, exp);
      chk({name, "_latency"}, 32'(lat), 32'(el));
      chk({name, "_busy_cycles"}, 32'(busy_n), 32'(el));
      @(posedge ip_clk_tb);
      #1;
      chk({name, "_done_one_cycle"}, {31'd0, bus.op_done}, 32'd0);
      chk({name, "_result_hold"}, bus.op_result, exp);
      last_exp = exp;
   endtask

   initial begin
      logic [31:0] res, ra, rb;
      logic [2:0]  rf;
      int          lat, busy_n, done_seen;

      bus.ip_start     = 1'b0;
      bus.ip_funct_3   = 3'b100;
      bus.ip_operand_a = '0;
      bus.ip_operand_b = '0;
      bus.ip_flush     = 1'b0;
      ip_rst_n_tb      = 1'b0;

      vq.push_back('{"divu_100_7",      3'b101, 32'd100,       32'd7,         32'd14});
      vq.push_back('{"rem_m100_7",      3'b110, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE});
      vq.push_back('{"div_m100_7",      3'b100, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2});
      vq.push_back('{"div_5_0",         3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF});
      vq.push_back('{"remu_5_0",        3'b111, 32'd5,         32'd0,         32'd5});
      vq.push_back('{"div_m5_0",        3'b100, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF});
      vq.push_back('{"rem_m5_0",        3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB});
      vq.push_back('{"div_ovf",         3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
      vq.push_back('{"rem_ovf",         3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0});
      vq.push_back('{"divu_min_ones",   3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0});
      vq.push_back('{"remu_ones_fe",    3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1});
      vq.push_back('{"div_min_1",       3'b100, 32'h8000_0000, 32'd1,         32'h8000_0000});
      vq.push_back('{"div_7_m2",        3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD});
      vq.push_back('{"rem_7_m2",        3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1});
      vq.push_back('{"remu_3_5",        3'b111, 32'd3,         32'd5,         32'd3});

      repeat (3) @(posedge ip_clk_tb);
      #1;
      chk("reset_busy",   {31'd0, bus.op_busy}, 32'd0);
      chk("reset_done",   {31'd0, bus.op_done}, 32'd0);
      chk("reset_result", bus.op_result, 32'd0);
      ip_rst_n_tb = 1'b1;
      @(posedge ip_clk_tb);
      #1;

      foreach (vq[i]) run_check(vq[i].name, vq[i].f, vq[i].a, vq[i].b, vq[i].exp);

      // Flush in cycle 10 of a DIVU, restart in the following cycle
      issue(3'b101, 32'd1000, 32'd3);
      @(posedge ip_clk_tb);
      #1;
      bus.ip_start = 1'b0;
      repeat (9) @(posedge ip_clk_tb);
      #1;
      bus.ip_flush = 1'b1;
      @(posedge ip_clk_tb);
      #1;
      bus.ip_flush = 1'b0;
      chk("flush_busy",   {31'd0, bus.op_busy}, 32'd0);
      chk("flush_done",   {31'd0, bus.op_done}, 32'd0);
      chk("flush_result", bus.op_result, last_exp);
      run_check("after_flush", 3'b101, 32'd1000, 32'd3, 32'd333);

      // Back-to-back: REMU issued in the DONE cycle of a DIVU, start pulses during CALC
      issue(3'b101, 32'd1000, 32'd7);
      complete(res, lat, busy_n);
      chk("b2b_first_result", res, 32'd142);
      issue(3'b111, 32'd17, 32'd5);
      @(posedge ip_clk_tb);
      #1;
      bus.ip_start = 1'b0;
      lat = 1;
      while (!bus.op_done && lat < 100) begin
         if (lat == 5 || lat == 20) issue(3'b101, 32'd99, 32'd2);
         else bus.ip_start = 1'b0;
         @(posedge ip_clk_tb);
         #1;
         lat++;
      end
      bus.ip_start = 1'b0;
      chk("b2b_second_result",  bus.op_result, 32'd2);
      chk("b2b_second_latency", 32'(lat), 32'd34);
      @(posedge ip_clk_tb);
      #1;

      // Random operations against the model, biased toward the corner cases
      for (int n = 0; n < 60; n++) begin
         rf = 3'(4 + $urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 15));
            3: begin ra = 32'($urandom_range(0, 200)); rb = 32'($urandom_range(1, 300)); end
            default: ;
         endcase
         run_check("rand", rf, ra, rb, model(rf, ra, rb));
      end

      // Asynchronous reset in the middle of an operation
      issue(3'b101, 32'd50, 32'd5);
      @(posedge ip_clk_tb);
      #1;
      bus.ip_start = 1'b0;
      repeat (5) @(posedge ip_clk_tb);
      #3;
      ip_rst_n_tb = 1'b0;
      #1;
      chk("midreset_busy",   {31'd0, bus.op_busy}, 32'd0);
      chk("midreset_done",   {31'd0, bus.op_done}, 32'd0);
      chk("midreset_result", bus.op_result, 32'd0);
      @(posedge ip_clk_tb);
      #1;
      ip_rst_n_tb = 1'b1;
      done_seen = 0;
      repeat (40) begin
         @(posedge ip_clk_tb);
         #1;
         if (bus.op_done) done_seen++;
      end
      chk("midreset_no_done", 32'(done_seen), 32'd0);
      run_check("after_reset", 3'b101, 32'd50, 32'd5, 32'd10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
